ov7670_capture: RTL and testbench
=================================

# ov7670_capture

Capture front end between the OV7670 camera port and `frame_buffer`'s write side. It runs entirely in the camera pixel-clock domain. Each pair of bytes is assembled into one RGB565 pixel. An optional integer decimation reduces the frame to the buffer size. The block drives `we`/`wAddr`/`wData` directly into the buffer and flags frame completion and address overflow.

## Interface
- `IMG_WIDTH`, 160: stored pixels per line after decimation.
- `IMG_HEIGHT`, 120: stored lines per frame after decimation.
- `SCALE`, 1: decimation factor (1, 2 or 4). Keeps one pixel in `SCALE` horizontally and one line in `SCALE` vertically.
- `ADDR_WIDTH`, `$clog2(IMG_WIDTH*IMG_HEIGHT)`: write address width.
- `pclk` input, 1 bit: camera pixel clock. It is the only clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `vsync` input, 1 bit: camera VSYNC, active high during vertical blanking.
- `href` input, 1 bit: camera HREF, high while line bytes are valid.
- `din` input, 8 bits: camera data bus.
- `we` output, 1 bit: one-cycle write strobe to the frame buffer.
- `wAddr` output, `ADDR_WIDTH` bits: write address.
- `wData` output, 16 bits: RGB565 pixel, `{first byte, second byte}`.
- `frame_active` output, 1 bit: high while a frame is being captured.
- `frame_done` output, 1 bit: one-cycle pulse when a frame ends.
- `overflow` output, 1 bit: sticky for the current frame; set when a write was dropped because the address would exceed `IMG_WIDTH*IMG_HEIGHT-1`.

## Operation
- FSM states:
  - `SYNC`: entered on reset. Waits for `vsync`=1, so a partial frame after reset is never captured.
  - `VBLANK`: waits for `vsync`=0, then goes to `ACTIVE`.
  - `ACTIVE`: capture. `vsync`=1 returns the FSM to `VBLANK` and pulses `frame_done`.
- On the `VBLANK`→`ACTIVE` transition:
  - the address counter, column counter and row counter clear to 0;
  - the byte phase clears to 0;
  - `overflow` clears.
- Byte pairing:
  - Applies only in `ACTIVE` with `href`=1.
  - Phase 0 latches `din` as the high byte. Phase 1 forms the pixel `{hi, din}`.
  - The phase toggles every `href`=1 cycle and resets to 0 on every `href` rising edge.
  - A dangling phase-0 byte at `href` fall is discarded.
- Column counter:
  - Increments per formed pixel and clears on `href` fall.
- Row counter:
  - Increments on each `href` falling edge in `ACTIVE`.
- Keep condition:
  - A pixel is kept when `col % SCALE == 0` and `row % SCALE == 0`.
  - For SCALE a power of two, this is an AND on the low bits; no divider.
- Kept pixel, address in range:
  - `we`=1, `wData`=pixel, `wAddr`=address counter.
  - The address counter then increments.
- Kept pixel, address counter equal to `IMG_WIDTH*IMG_HEIGHT`:
  - `we` stays 0 and `overflow` sets.
  - The counter saturates and does not wrap.
- `frame_done` pulses on every `ACTIVE`→`VBLANK` transition, including short or overflowed frames.
- `frame_active` = (state == `ACTIVE`).
- `vsync` rising mid-line ends the frame immediately. A pending high byte is discarded.

## Timing
- All inputs are sampled on the rising edge of `pclk`.
- All outputs are registered.
- Reset values: `we`=0, `wAddr`=0, `wData`=0, `frame_active`=0, `frame_done`=0, `overflow`=0. FSM = `SYNC`, all counters 0.
- Latency: if the high byte is sampled at edge k and the low byte at edge k+1, then `we`, `wData` and `wAddr` update at edge k+1 and are valid for exactly one cycle.
- Maximum write rate is one `we` every 2 cycles.
- `wAddr`/`wData` hold their last value when `we`=0.
- `frame_done` is asserted for the one cycle following the edge at which `vsync`=1 is first sampled in `ACTIVE`. `frame_active` falls on the same edge.
- `rst_n` low mid-frame clears everything asynchronously. After release, the FSM waits in `SYNC` for the next `vsync` high.

## Structure
- Shared package `ov7670_pkg`: the `capture_state_t` enum (`SYNC`, `VBLANK`, `ACTIVE`) and the RGB565 typedef `rgb565_t` (`r[4:0]`, `g[5:0]`, `b[4:0]`). `frame_buffer` and downstream readers share `rgb565_t`.
- One sub-module, `ov7670_byte_pair`: phase toggle, high-byte latch, `href` edge detect. Outputs `pix_valid`, `pix`, `line_end`.
- The top level holds the FSM, counters, decimation and overflow logic.

## Test plan
- **Full frame:** IMG 4x2, SCALE 1. Drive `vsync` 1→0, then 2 lines of 8 bytes `0x00..0x0F`, then `vsync`=1. Expect 8 writes, addresses 0..7, data `0x0001`, `0x0203`, …, `0x0E0F`, and one `frame_done` pulse.
- **Reset mid-frame:** `rst_n` low mid-frame, then released while `vsync`=0 with `href` activity. Expect `we`=0 until a full `vsync` high→low cycle, after which the capture starts at `wAddr`=0.
- **Odd byte:** a line with 7 bytes. Expect 3 writes; the 7th byte is dropped, and the next line's first pixel pairs correctly.
- **Decimation:** SCALE 2, IMG 2x2, source frame 4 lines of 8 bytes (4 pixels each). Expect writes only from pixels 0 and 2 of lines 0 and 2, at addresses 0..3.
- **Overflow:** IMG 2x1, SCALE 1, one line of 4 pixels. Expect writes at addresses 0 and 1 only, `overflow`=1 from the third pixel, cleared at the next frame start.
- **Early VSYNC:** `vsync` rises after the high byte of a pixel. Expect no write for that byte, `frame_done`=1 for exactly one cycle, and `frame_active` low on the same edge.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types for the OV7670 capture path.
//   capture_state_t : capture FSM states (SYNC, VBLANK, ACTIVE)
//   rgb565_t        : packed RGB565 pixel, shared with frame_buffer and readers
package ov7670_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2
  } capture_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive camera bytes into RGB565 pixels.
//   pclk, rst_n : pixel clock, async active-low reset
//   en          : pairing enabled (frame active and vsync low)
//   href, din   : camera line-valid and data bus
//   pix_valid   : low byte present this cycle, pix is complete
//   pix         : {held high byte, din}
//   line_end    : href falling edge sampled this cycle
import ov7670_pkg::*;

module ov7670_byte_pair (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       href,
  input  logic [7:0] din,
  output logic       pix_valid,
  output rgb565_t    pix,
  output logic       line_end
);

  logic       phase;
  logic [7:0] hi;
  logic       href_d;

  // Phase is cleared whenever href (or en) is low, so every line starts on a
  // high byte and an unpaired trailing byte is simply forgotten.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 1'b0;
      hi     <= '0;
      href_d <= 1'b0;
    end else begin
      href_d <= href;
      if (en && href) begin
        phase <= ~phase;
        if (!phase) hi <= din;
      end else begin
        phase <= 1'b0;
      end
    end
  end

  assign pix_valid = en && href && phase;
  assign pix       = rgb565_t'({hi, din});
  assign line_end  = en && href_d && !href;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture front end, pclk domain only.
//   pclk, rst_n        : pixel clock, async active-low reset
//   vsync, href, din   : camera sync and data inputs
//   we, wAddr, wData   : frame_buffer write port (registered)
//   frame_active       : capture FSM in ACTIVE
//   frame_done         : one-cycle pulse at end of each frame
//   overflow           : a kept pixel was dropped past the last address
import ov7670_pkg::*;

module ov7670_capture #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int SCALE      = 1,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [7:0]            din,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [15:0]           wData,
  output logic                  frame_active,
  output logic                  frame_done,
  output logic                  overflow
);

  // One spare bit so the counter can hold IMG_WIDTH*IMG_HEIGHT itself
  // (the saturation value) even when that is an exact power of two.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ADDR_MAX = CW'(IMG_WIDTH*IMG_HEIGHT);
  localparam logic [15:0]   SMASK    = 16'(SCALE - 1);

  capture_state_t state, next_state;

  logic [CW-1:0] addr;
  logic [15:0]   col;
  logic [15:0]   row;
  logic          pix_valid;
  rgb565_t       pix;
  logic          line_end;
  logic          pair_en;
  logic          frame_start;
  logic          frame_end;
  logic          keep;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SYNC:    if (vsync)  next_state = VBLANK;
      VBLANK:  if (!vsync) next_state = ACTIVE;
      ACTIVE:  if (vsync)  next_state = VBLANK;
      default: next_state = SYNC;
    endcase
  end

  assign frame_start = (state == VBLANK) && !vsync;
  assign frame_end   = (state == ACTIVE) && vsync;
  // vsync sampled high ends the frame on that same edge, so nothing it
  // carries may be paired.
  assign pair_en     = (state == ACTIVE) && !vsync;
  assign keep        = ((col & SMASK) == '0) && ((row & SMASK) == '0);

  ov7670_byte_pair u_byte_pair (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .en        (pair_en),
    .href      (href),
    .din       (din),
    .pix_valid (pix_valid),
    .pix       (pix),
    .line_end  (line_end)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      col        <= '0;
      row        <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= frame_end;
      if (frame_start) begin
        addr     <= '0;
        col      <= '0;
        row      <= '0;
        overflow <= 1'b0;
      end else if (pix_valid) begin
        col <= col + 16'd1;
        if (keep) begin
          if (addr == ADDR_MAX) begin
            overflow <= 1'b1;
          end else begin
            we    <= 1'b1;
            wAddr <= addr[ADDR_WIDTH-1:0];
            wData <= pix;
            addr  <= addr + CW'(1);
          end
        end
      end else if (line_end) begin
        col <= '0;
        row <= row + 16'd1;
      end
    end
  end

  assign frame_active = (state == ACTIVE);

endmodule

// File: tb/tb_ov7670_capture.sv
module tb_ov7670_capture;

  logic       pclk;
  logic       rst_n;
  logic       vsync;
  logic       href;
  logic [7:0] din;

  // dut_a: 4x2 SCALE 1, dut_b: 2x2 SCALE 2, dut_c: 2x1 SCALE 1
  logic        a_we, a_act, a_done, a_ovf;
  logic [2:0]  a_addr;
  logic [15:0] a_data;
  logic        b_we, b_act, b_done, b_ovf;
  logic [1:0]  b_addr;
  logic [15:0] b_data;
  logic        c_we, c_act, c_done, c_ovf;
  logic [0:0]  c_addr;
  logic [15:0] c_data;

  int n_checks = 0;
  int n_errors = 0;
  int qa_addr[$], qa_data[$];
  int qb_addr[$], qb_data[$];
  int qc_addr[$], qc_data[$];
  int fd_a = 0;

  ov7670_capture #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .SCALE(1)) dut_a (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
    .we(a_we), .wAddr(a_addr), .wData(a_data),
    .frame_active(a_act), .frame_done(a_done), .overflow(a_ovf));

  ov7670_capture #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .SCALE(2)) dut_b (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
    .we(b_we), .wAddr(b_addr), .wData(b_data),
    .frame_active(b_act), .frame_done(b_done), .overflow(b_ovf));

  ov7670_capture #(.IMG_WIDTH(2), .IMG_HEIGHT(1), .SCALE(1)) dut_c (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
    .we(c_we), .wAddr(c_addr), .wData(c_data),
    .frame_active(c_act), .frame_done(c_done), .overflow(c_ovf));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (a_we) begin qa_addr.push_back(int'(a_addr)); qa_data.push_back(int'(a_data)); end
    if (b_we) begin qb_addr.push_back(int'(b_addr)); qb_data.push_back(int'(b_data)); end
    if (c_we) begin qc_addr.push_back(int'(c_addr)); qc_data.push_back(int'(c_data)); end
    if (a_done) fd_a++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v, input logic h, input logic [7:0] d);
    vsync = v; href = h; din = d;
    @(posedge pclk);
    #1;
  endtask

  task automatic start_frame();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_line(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, base + 8'(i));
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_logs();
    qa_addr.delete(); qa_data.delete();
    qb_addr.delete(); qb_data.delete();
    qc_addr.delete(); qc_data.delete();
  endtask

  initial begin
    int fd0;
    int exp_b[4];
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; din = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_we",    a_we,   0);
    check("rst_waddr", a_addr, 0);
    check("rst_wdata", a_data, 0);
    check("rst_act",   a_act,  0);
    check("rst_done",  a_done, 0);
    check("rst_ovf",   a_ovf,  0);
    rst_n = 1'b1;

    // Full frame: 2 lines of 8 bytes 0x00..0x0F
    clear_logs();
    fd0 = fd_a;
    start_frame();
    check("full_act", a_act, 1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 8'(i));
      if (i == 1) begin
        check("lat_we",   a_we,   1);
        check("lat_addr", a_addr, 0);
        check("lat_data", a_data, 16'h0001);
      end
      if (i == 2) check("lat_we_1cyc", a_we, 0);
    end
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    send_line(8'h08, 8);
    end_frame();
    tick(1'b1, 1'b0, 8'h00);
    check("full_cnt", qa_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("full_addr", qa_addr[i], i);
      check("full_data", qa_data[i], {8'(2*i), 8'(2*i+1)});
    end
    check("full_fdone", fd_a - fd0, 1);
    check("hold_data", a_data, 16'h0E0F);
    check("hold_we",   a_we, 0);

    // Reset mid-frame, released with href activity while vsync low
    start_frame();
    tick(1'b0, 1'b1, 8'h10);
    tick(1'b0, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 8'h12);
    rst_n = 1'b0;
    #1;
    check("arst_act",  a_act, 0);
    check("arst_we",   a_we,  0);
    check("arst_addr", a_addr, 0);
    tick(1'b0, 1'b1, 8'h13);
    clear_logs();
    rst_n = 1'b1;
    send_line(8'h10, 8);
    send_line(8'h18, 8);
    check("arst_nowr", qa_addr.size(), 0);
    check("arst_sync", a_act, 0);
    start_frame();
    send_line(8'h20, 8);
    end_frame();
    check("arst_cnt",  qa_addr.size(), 4);
    check("arst_addr0", qa_addr[0], 0);
    check("arst_data0", qa_data[0], 16'h2021);

    // Odd byte: 7-byte line then a normal line
    clear_logs();
    start_frame();
    send_line(8'h30, 7);
    send_line(8'h40, 8);
    end_frame();
    check("odd_cnt", qa_addr.size(), 7);
    check("odd_d2",  qa_data[2], 16'h3435);
    check("odd_a3",  qa_addr[3], 3);
    check("odd_d3",  qa_data[3], 16'h4041);
    check("odd_d6",  qa_data[6], 16'h4647);

    // Decimation on dut_b: 4 lines, bytes L*16 + i
    clear_logs();
    start_frame();
    for (int l = 0; l < 4; l++) send_line(8'(l*16), 8);
    end_frame();
    exp_b = '{32'h0001, 32'h0405, 32'h2021, 32'h2425};
    check("dec_cnt", qb_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("dec_addr", qb_addr[i], i);
      check("dec_data", qb_data[i], exp_b[i]);
    end
    check("dec_ovf", b_ovf, 0);

    // Overflow on dut_c: one line of 4 pixels
    clear_logs();
    start_frame();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 8'h60 + 8'(i));
      if (i == 3) check("ovf_pre",  c_ovf, 0);
      if (i == 5) check("ovf_set",  c_ovf, 1);
    end
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    check("ovf_cnt", qc_addr.size(), 2);
    check("ovf_a1",  qc_addr[1], 1);
    check("ovf_d0",  qc_data[0], 16'h6061);
    check("ovf_d1",  qc_data[1], 16'h6263);
    end_frame();
    check("ovf_sticky", c_ovf, 1);
    tick(1'b0, 1'b0, 8'h00);
    check("ovf_clear", c_ovf, 0);
    tick(1'b0, 1'b0, 8'h00);

    // Early vsync after a high byte
    clear_logs();
    fd0 = fd_a;
    tick(1'b0, 1'b1, 8'h70);
    tick(1'b1, 1'b1, 8'h71);
    check("early_done", a_done, 1);
    check("early_act",  a_act,  0);
    check("early_we",   a_we,   0);
    tick(1'b1, 1'b0, 8'h00);
    check("early_done1", a_done, 0);
    tick(1'b1, 1'b0, 8'h00);
    check("early_nowr", qa_addr.size(), 0);
    check("early_fdcnt", fd_a - fd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
